// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier arbiter: FSM state encoding,
// operand/product widths and default configuration.
package mult_arb_pkg;

    localparam int OP_W        = 64;
    localparam int PROD_W      = 128;
    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_arb_m_rr.sv
// Round-robin arbiter: combinational one-hot grant searched from last+1,
// with a registered last-grant pointer loaded on upd_en.
module rr_arbiter_m #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 upd_en,
    input  logic [$clog2(N)-1:0] upd_idx,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_q;
    int            idx;

    // Reset to N-1 so the first contended grant goes to lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IW'(N - 1);
        end else if (upd_en) begin
            last_q <= upd_idx;
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt_idx  = IW'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arb_m.sv
// Arbitrates N_REQ requesters onto one shared sequential 64x64 multiplier.
// Optional BUSY watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arb_m
    import mult_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*OP_W-1:0]   req_a,
    input  logic [N_REQ*OP_W-1:0]   req_b,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [PROD_W-1:0]       rsp_p,
    output logic                    rsp_err,
    output logic                    mul_start,
    input  logic                    mul_ready,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [PROD_W-1:0]       mul_p,
    output logic [1:0]              dbg_state
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("mult_arb_m: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    // Handshakes: a request transfers in the IDLE cycle where req_valid[i]
    // and req_ready[i] are both high; a response transfers in the RESP cycle
    // where rsp_valid[g] and rsp_ready[g] are both high. Valid never drops
    // before its transfer, and payload stays stable while valid is high.

    state_t        state;
    logic [IW-1:0] g_q;
    logic          seen_low;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic          rsp_done;

    assign rsp_done  = (state == RESP) && rsp_ready[g_q];
    assign req_ready = (state == IDLE && !rst) ? gnt : '0;
    assign mul_start = (state == ISSUE) && mul_ready && !rst;
    assign dbg_state = state;

    rr_arbiter_m #(.N(N_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .upd_en  (rsp_done),
        .upd_idx (g_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] to_cnt;
    logic          err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            g_q       <= '0;
            seen_low  <= 1'b0;
            rsp_valid <= '0;
            rsp_p     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        mul_a <= req_a[int'(gnt_idx)*OP_W +: OP_W];
                        mul_b <= req_b[int'(gnt_idx)*OP_W +: OP_W];
                        g_q   <= gnt_idx;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_ready) begin
                        seen_low <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // The multiplier may still show ready from before start;
                    // only a ready after a low phase marks a fresh product.
                    if (!mul_ready) begin
                        seen_low <= 1'b1;
                    end
                    if (mul_ready && seen_low) begin
                        rsp_p     <= mul_p;
                        rsp_valid <= N_REQ'(1) << g_q;
`ifdef MULT_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef MULT_ARB_TIMEOUT_EN
                    else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_p     <= '0;
                        rsp_valid <= N_REQ'(1) << g_q;
                        err_q     <= 1'b1;
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready[g_q]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arb_m.sv
// Self-checking bench for mult_arb_m with a behavioural sequential multiplier.
// Timeout scenario adapts to whether MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_arb_m;
    import mult_arb_pkg::*;

    localparam int N       = 4;
    localparam int TO      = 16;
    localparam int MUL_LAT = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*64-1:0] req_a, req_b;
    logic [127:0]   rsp_p, mul_p;
    logic           rsp_err, mul_start, mul_ready;
    logic [63:0]    mul_a, mul_b;
    logic [1:0]     dbg_state;

    logic [127:0]   exp_q[$];
    int             exp_lane_q[$];
    int             n_checks = 0;
    int             n_fail = 0;

    logic           stuck;
    logic           mbusy;
    int             mcnt;

    always #5 clk = ~clk;

    mult_arb_m #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_p(rsp_p), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_ready(mul_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .dbg_state(dbg_state)
    );

    // Sequential multiplier: ready drops after start, returns MUL_LAT cycles later.
    always @(posedge clk) begin
        if (rst) begin
            mul_ready <= 1'b1;
            mbusy     <= 1'b0;
            mcnt      <= 0;
            mul_p     <= '0;
        end else if (mbusy) begin
            if (!stuck) begin
                if (mcnt <= 1) begin
                    mul_ready <= 1'b1;
                    mbusy     <= 1'b0;
                    mul_p     <= {64'b0, mul_a} * {64'b0, mul_b};
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end else if (mul_start) begin
            mbusy     <= 1'b1;
            mul_ready <= 1'b0;
            mcnt      <= MUL_LAT - 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic rst_dut();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one request on lane; ok reports whether it was granted in time.
    task automatic send(input int lane, input logic [63:0] a, input logic [63:0] b, output bit ok);
        req_a[lane*64 +: 64] = a;
        req_b[lane*64 +: 64] = b;
        req_valid[lane] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            #2;
            if (req_ready[lane]) ok = 1'b1;
            @(negedge clk);
        end
        req_valid[lane] = 1'b0;
    endtask

    // Wait for a response; lat counts negedges starting at 1 right after grant.
    task automatic collect(input int lim, input bit ack, output bit got, output int lane,
                           output logic [127:0] p, output logic err, output int lat);
        got = 1'b0; lane = 0; p = '0; err = 1'b0; lat = 0;
        for (int k = 1; k <= lim && !got; k++) begin
            if (|rsp_valid) begin
                got = 1'b1;
                lat = k;
                p   = rsp_p;
                err = rsp_err;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) lane = i;
            end else begin
                @(negedge clk);
            end
        end
        if (got && ack) begin
            rsp_ready[lane] = 1'b1;
            @(negedge clk);
            rsp_ready = '0;
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        repeat (2) @(negedge clk);
        n_checks += 8;
        if (req_ready !== '0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        if (rsp_valid !== '0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        if (rsp_p !== '0) begin n_fail++; $display("FAIL rst_rsp_p: got %0h want 0", rsp_p); end
        if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        if (mul_start !== 1'b0) begin n_fail++; $display("FAIL rst_mul_start: got %b want 0", mul_start); end
        if (mul_a !== '0) begin n_fail++; $display("FAIL rst_mul_a: got %0h want 0", mul_a); end
        if (mul_b !== '0) begin n_fail++; $display("FAIL rst_mul_b: got %0h want 0", mul_b); end
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok, got; int lane, lat; logic [127:0] p; logic err;
        logic [127:0] e;
        exp_q.push_back(128'd15);
        send(0, 64'd3, 64'd5, ok);
        collect(60, 1'b0, got, lane, p, err, lat);
        e = exp_q.pop_front();
        n_checks += 6;
        if (!ok) begin n_fail++; $display("FAIL basic_grant: got no req_ready want lane 0"); end
        if (!got || lane != 0) begin n_fail++; $display("FAIL basic_lane: got %0d (valid %b) want 0", lane, got); end
        if (p !== e || err !== 1'b0) begin n_fail++; $display("FAIL basic_p: got %0h err %b want %0h err 0", p, err, e); end
        if (lat != 2 + MUL_LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, 2 + MUL_LAT); end
        if (mul_a !== 64'd3 || mul_b !== 64'd5) begin n_fail++; $display("FAIL basic_operands: got %0h,%0h want 3,5", mul_a, mul_b); end
        if (dbg_state !== RESP) begin n_fail++; $display("FAIL basic_state: got %0d want %0d", dbg_state, RESP); end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_max();
        bit ok, got; int lane, lat; logic [127:0] p; logic err;
        logic [127:0] e;
        exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        send(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, ok);
        collect(60, 1'b1, got, lane, p, err, lat);
        e = exp_q.pop_front();
        n_checks += 2;
        if (!ok || !got || lane != 2) begin n_fail++; $display("FAIL max_lane: got %0d (grant %b rsp %b) want 2", lane, ok, got); end
        if (p !== e || err !== 1'b0) begin n_fail++; $display("FAIL max_p: got %0h err %b want %0h", p, err, e); end
    endtask

    task automatic test_rr();
        bit gok, got; int lane, lat; logic [127:0] p; logic err;
        int exp_g; logic [N-1:0] g_seen; logic [N-1:0] g_exp;
        rst_dut();
        exp_g = N - 1;
        for (int i = 0; i < N; i++) begin
            req_a[i*64 +: 64] = 64'(i + 1);
            req_b[i*64 +: 64] = 64'd10;
        end
        req_valid = '1;
        for (int r = 0; r < 5; r++) begin
            gok = 1'b0; g_seen = '0;
            for (int k = 0; k < 50 && !gok; k++) begin
                #2;
                if (|req_ready) begin gok = 1'b1; g_seen = req_ready; end
                @(negedge clk);
            end
            exp_g = (exp_g + 1) % N;
            g_exp = N'(1) << exp_g;
            exp_q.push_back(128'((exp_g + 1) * 10));
            exp_lane_q.push_back(exp_g);
            collect(60, 1'b1, got, lane, p, err, lat);
            n_checks += 3;
            if (g_seen !== g_exp) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", r, g_seen, g_exp); end
            if (!got || lane != exp_lane_q.pop_front()) begin n_fail++; $display("FAIL rr_lane%0d: got %0d want %0d", r, lane, exp_g); end
            if (p !== exp_q.pop_front()) begin n_fail++; $display("FAIL rr_p%0d: got %0d want %0d", r, p, (exp_g + 1) * 10); end
        end
        req_valid = '0;
        // Drain the grant that may already have been taken after the last ack.
        if (dbg_state != IDLE) begin
            collect(60, 1'b1, got, lane, p, err, lat);
        end
    endtask

    task automatic test_hold();
        bit ok, got; int lane, lat; logic [127:0] p; logic err;
        send(1, 64'd7, 64'd9, ok);
        collect(60, 1'b0, got, lane, p, err, lat);
        n_checks++;
        if (!ok || !got || lane != 1 || p !== 128'd63) begin n_fail++; $display("FAIL hold_first: got lane %0d p %0d want lane 1 p 63", lane, p); end
        req_valid = 4'b1101;
        rsp_ready = 4'b1101;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL hold_valid%0d: got %b want 0010", c, rsp_valid); end
            if (rsp_p !== 128'd63) begin n_fail++; $display("FAIL hold_p%0d: got %0d want 63", c, rsp_p); end
            if (req_ready !== '0) begin n_fail++; $display("FAIL hold_req_ready%0d: got %b want 0", c, req_ready); end
            if (mul_start !== 1'b0) begin n_fail++; $display("FAIL hold_mul_start%0d: got %b want 0", c, mul_start); end
        end
        req_valid = '0;
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = '0;
        n_checks++;
        if (rsp_valid !== '0) begin n_fail++; $display("FAIL hold_release: got %b want 0", rsp_valid); end
    endtask

    task automatic test_skip();
        bit gok, got; int lane, lat; logic [127:0] p; logic err;
        logic [N-1:0] g_seen;
        req_a[2*64 +: 64] = 64'd4;  req_b[2*64 +: 64] = 64'd6;
        req_a[3*64 +: 64] = 64'd8;  req_b[3*64 +: 64] = 64'd8;
        req_a[0*64 +: 64] = 64'd12; req_b[0*64 +: 64] = 64'd12;
        req_valid = 4'b1100;
        #2;
        g_seen = req_ready;
        @(negedge clk);
        req_valid = 4'b1001;
        repeat (2) @(negedge clk);
        req_valid = 4'b0001;
        collect(60, 1'b1, got, lane, p, err, lat);
        n_checks += 2;
        if (g_seen !== 4'b0100) begin n_fail++; $display("FAIL skip_grant_a: got %b want 0100", g_seen); end
        if (!got || lane != 2 || p !== 128'd24) begin n_fail++; $display("FAIL skip_p_a: got lane %0d p %0d want lane 2 p 24", lane, p); end
        #2;
        g_seen = req_ready;
        @(negedge clk);
        req_valid = '0;
        collect(60, 1'b1, got, lane, p, err, lat);
        n_checks += 2;
        if (g_seen !== 4'b0001) begin n_fail++; $display("FAIL skip_grant_b: got %b want 0001", g_seen); end
        if (!got || lane != 0 || p !== 128'd144) begin n_fail++; $display("FAIL skip_p_b: got lane %0d p %0d want lane 0 p 144", lane, p); end
    endtask

    task automatic test_random();
        bit ok, got; int lane, lat, l; logic [127:0] p; logic err;
        logic [63:0] a, b;
        for (int r = 0; r < 6; r++) begin
            l = $urandom_range(0, N - 1);
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            exp_q.push_back({64'b0, a} * {64'b0, b});
            exp_lane_q.push_back(l);
            send(l, a, b, ok);
            collect(60, 1'b1, got, lane, p, err, lat);
            n_checks += 2;
            if (!ok || !got || lane != exp_lane_q.pop_front()) begin n_fail++; $display("FAIL rand_lane%0d: got %0d want %0d", r, lane, l); end
            if (p !== exp_q.pop_front() || err !== 1'b0) begin n_fail++; $display("FAIL rand_p%0d: got %0h a %0h b %0h", r, p, a, b); end
        end
    endtask

    task automatic test_rst_busy();
        bit ok, got, seen_busy, stray; int lane, lat; logic [127:0] p; logic err;
        req_a[3*64 +: 64] = 64'd11; req_b[3*64 +: 64] = 64'd13;
        send(3, 64'd11, 64'd13, ok);
        seen_busy = 1'b0;
        for (int k = 0; k < 20 && !seen_busy; k++) begin
            if (dbg_state == BUSY) seen_busy = 1'b1;
            else @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks += 6;
        if (!seen_busy) begin n_fail++; $display("FAIL rb_busy: never reached BUSY"); end
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rb_state: got %0d want %0d", dbg_state, IDLE); end
        if (rsp_valid !== '0 || req_ready !== '0) begin n_fail++; $display("FAIL rb_handshake: got %b/%b want 0/0", rsp_valid, req_ready); end
        if (rsp_p !== '0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rb_rsp: got %0h/%b want 0/0", rsp_p, rsp_err); end
        if (mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL rb_mul_ab: got %0h/%0h want 0/0", mul_a, mul_b); end
        if (mul_start !== 1'b0) begin n_fail++; $display("FAIL rb_mul_start: got %b want 0", mul_start); end
        rst = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (|rsp_valid) stray = 1'b1;
        end
        n_checks++;
        if (stray) begin n_fail++; $display("FAIL rb_no_rsp: got a response after reset want none"); end
        exp_q.push_back(128'd42);
        send(3, 64'd2, 64'd21, ok);
        collect(60, 1'b1, got, lane, p, err, lat);
        n_checks++;
        if (!ok || !got || lane != 3 || p !== exp_q.pop_front()) begin n_fail++; $display("FAIL rb_after: got lane %0d p %0d want lane 3 p 42", lane, p); end
    endtask

    task automatic test_timeout();
        bit ok, got; int lane, lat; logic [127:0] p; logic err;
        stuck = 1'b1;
        send(0, 64'd1, 64'd2, ok);
`ifdef MULT_ARB_TIMEOUT_EN
        collect(60, 1'b1, got, lane, p, err, lat);
        n_checks += 3;
        if (!ok || !got || lane != 0) begin n_fail++; $display("FAIL to_lane: got %0d (rsp %b) want 0", lane, got); end
        if (err !== 1'b1 || p !== '0) begin n_fail++; $display("FAIL to_err: got err %b p %0h want err 1 p 0", err, p); end
        if (lat != 2 + TO) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", lat, 2 + TO); end
`else
        collect(60, 1'b0, got, lane, p, err, lat);
        n_checks += 2;
        if (!ok || got) begin n_fail++; $display("FAIL to_none: got rsp %b grant %b want rsp 0 grant 1", got, ok); end
        if (dbg_state !== BUSY) begin n_fail++; $display("FAIL to_state: got %0d want %0d", dbg_state, BUSY); end
`endif
        rst_dut();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        stuck = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_rr();
        test_hold();
        test_skip();
        test_random();
        test_rst_busy();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
